k_wr_strobe: RTL and testbench

K_WR_STROBE -- requirements
Module: k_wr_strobe

---
 rtl/k_wr_strobe.sv | 122 ++++++++++++
 tb/tb_k_wr_strobe.sv | 107 ++++++++++
 2 files changed

// File: rtl/k_wr_strobe.sv
// CPU write-strobe generator: qualifies 68k-style write cycles and emits one-hot byte-lane load pulses plus DTACK.
// Optional input synchronizers are enabled by defining STROBE_SYNC_EN (depth SYNC_STAGES).
module k_wr_strobe #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        nAS,
  input  logic        RW,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic [3:0]  ADDR,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic [15:0] LOADH,
  output logic [15:0] LOADL,
  output logic        nDTACK
);

  localparam int unsigned NREG = 16;

  typedef enum logic [1:0] {IDLE, STROBE, ACK} state_t;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("k_wr_strobe: SYNC_STAGES must be 2 or 3");
  end

  logic as_n_s, uds_n_s, lds_n_s, rw_s, cs_s;
  logic sync_vld;

`ifdef STROBE_SYNC_EN
  // Stage vector order {nAS, nUDS, nLDS, RW, CS}; reset leaves the bus looking idle.
  localparam logic [4:0] SYNC_RST = 5'b11100;

  logic [4:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] vld_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SYNC_RST;
      vld_q <= '0;
    end else begin
      sync_q[0] <= {nAS, nUDS, nLDS, RW, CS};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      vld_q <= {vld_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // The reset fill values must not count as a genuine nAS-high sample.
  assign {as_n_s, uds_n_s, lds_n_s, rw_s, cs_s} = sync_q[SYNC_STAGES-1];
  assign sync_vld = vld_q[SYNC_STAGES-1];
`else
  assign {as_n_s, uds_n_s, lds_n_s, rw_s, cs_s} = {nAS, nUDS, nLDS, RW, CS};
  assign sync_vld = 1'b1;
`endif

  state_t         state, state_nxt;
  logic           armed, armed_nxt;
  logic [NREG-1:0] loadh_nxt, loadl_nxt;
  logic [15:0]    dout_nxt;
  logic           ndtack_nxt;
  logic           qual;

  // Armed only after nAS has been seen high, so a held-low nAS cannot re-trigger.
  assign qual = armed && cs_s && !as_n_s && !rw_s && (!uds_n_s || !lds_n_s);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      armed  <= 1'b0;
      LOADH  <= '0;
      LOADL  <= '0;
      DOUT   <= '0;
      nDTACK <= 1'b1;
    end else begin
      state  <= state_nxt;
      armed  <= armed_nxt;
      LOADH  <= loadh_nxt;
      LOADL  <= loadl_nxt;
      DOUT   <= dout_nxt;
      nDTACK <= ndtack_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    armed_nxt  = armed;
    loadh_nxt  = '0;
    loadl_nxt  = '0;
    dout_nxt   = DOUT;
    ndtack_nxt = 1'b1;

    if (sync_vld && as_n_s) armed_nxt = 1'b1;

    unique case (state)
      IDLE: begin
        if (qual) begin
          state_nxt = STROBE;
          armed_nxt = 1'b0;
          dout_nxt  = DIN;
          if (!uds_n_s) loadh_nxt = NREG'(1) << ADDR;
          if (!lds_n_s) loadl_nxt = NREG'(1) << ADDR;
        end
      end
      STROBE: begin
        if (!as_n_s) begin
          state_nxt  = ACK;
          ndtack_nxt = 1'b0;
        end else begin
          state_nxt  = IDLE;
        end
      end
      ACK: begin
        if (!as_n_s) ndtack_nxt = 1'b0;
        else         state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_k_wr_strobe.sv
// Directed self-checking bench for k_wr_strobe; latencies shift by 2 when STROBE_SYNC_EN is defined.
module tb_k_wr_strobe;

`ifdef STROBE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET, CS, nAS, RW, nUDS, nLDS;
  logic [3:0]  ADDR;
  logic [15:0] DIN, DOUT, LOADH, LOADL;
  logic        nDTACK;

  int checks   = 0;
  int failures = 0;

  k_wr_strobe #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET(RESET), .CS(CS), .nAS(nAS), .RW(RW), .nUDS(nUDS), .nLDS(nLDS),
    .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT), .LOADH(LOADH), .LOADL(LOADL), .nDTACK(nDTACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    nAS = 1'b1; CS = 1'b0; RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
  endtask

  // One bus cycle with nAS low for 'low' samples, checked every clock until the block is idle again.
  task automatic run_cycle(input string tag, input logic cs, input logic rw,
                           input logic nuds, input logic nlds, input logic [3:0] addr,
                           input logic [15:0] din, input int low,
                           input logic [15:0] exp_h, input logic [15:0] exp_l,
                           input logic [15:0] exp_dout);
    logic qual;
    qual = (exp_h | exp_l) != 16'h0;
    CS = cs; RW = rw; nUDS = nuds; nLDS = nlds; ADDR = addr; DIN = din; nAS = 1'b0;
    for (int i = 1; i <= low + LAT + 2; i++) begin
      if (i == low + 1) bus_idle();
      tick();
      chk($sformatf("%s.loadh[%0d]", tag, i), LOADH, (qual && i == LAT + 1) ? exp_h : 16'h0);
      chk($sformatf("%s.loadl[%0d]", tag, i), LOADL, (qual && i == LAT + 1) ? exp_l : 16'h0);
      chk($sformatf("%s.ndtack[%0d]", tag, i), {15'h0, nDTACK},
          (qual && i >= LAT + 2 && i <= low + LAT) ? 16'h0 : 16'h1);
    end
    chk($sformatf("%s.dout", tag), DOUT, exp_dout);
  endtask

  initial begin
    RESET = 1'b1; ADDR = 4'h0; DIN = 16'h0;
    bus_idle();
    repeat (3) tick();
    chk("rst.loadh", LOADH, 16'h0);
    chk("rst.loadl", LOADL, 16'h0);
    chk("rst.dout", DOUT, 16'h0);
    chk("rst.ndtack", {15'h0, nDTACK}, 16'h1);
    RESET = 1'b0;
    repeat (4) tick();

    run_cycle("word",    1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  16'hA55A, 6, 16'h0008, 16'h0008, 16'hA55A);
    run_cycle("byte_lo", 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 16'h1234, 3, 16'h0000, 16'h8000, 16'h1234);
    run_cycle("read",    1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  16'hFFFF, 3, 16'h0000, 16'h0000, 16'h1234);
    run_cycle("no_cs",   1'b0, 1'b0, 1'b0, 1'b0, 4'd2,  16'hFFFF, 3, 16'h0000, 16'h0000, 16'h1234);
    run_cycle("no_ds",   1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  16'hFFFF, 3, 16'h0000, 16'h0000, 16'h1234);
    run_cycle("short",   1'b1, 1'b0, 1'b0, 1'b1, 4'd0,  16'h00FF, 1, 16'h0001, 16'h0000, 16'h00FF);

    // Reset while in ACK with nAS still low.
    CS = 1'b1; RW = 1'b0; nUDS = 1'b0; nLDS = 1'b0; ADDR = 4'd5; DIN = 16'hBEEF; nAS = 1'b0;
    repeat (LAT + 2) tick();
    chk("rstack.pre_ndtack", {15'h0, nDTACK}, 16'h0);
    RESET = 1'b1;
    tick();
    chk("rstack.loadh", LOADH, 16'h0);
    chk("rstack.loadl", LOADL, 16'h0);
    chk("rstack.dout", DOUT, 16'h0);
    chk("rstack.ndtack", {15'h0, nDTACK}, 16'h1);
    RESET = 1'b0;
    for (int i = 1; i <= LAT + 4; i++) begin
      tick();
      chk($sformatf("held.loadh[%0d]", i), LOADH, 16'h0);
      chk($sformatf("held.loadl[%0d]", i), LOADL, 16'h0);
      chk($sformatf("held.ndtack[%0d]", i), {15'h0, nDTACK}, 16'h1);
    end
    bus_idle();
    repeat (LAT + 1) tick();
    chk("rearm.dout_before", DOUT, 16'h0);
    run_cycle("rearm", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 16'hBEEF, 2, 16'h0020, 16'h0020, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
